// File: rtl/vector_lsu_if.sv
// rtl/vector_lsu_if.sv - word memory req/ack port between the vector LSU and main memory
interface vector_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/vector_lsu.sv
// rtl/vector_lsu.sv - multi-cycle strided/masked vector load/store sequencer
module vector_lsu #(
    parameter int VLEN = 128
) (
    input  logic               SYS_clk,
    input  logic               SYS_reset,
    input  logic               start,
    input  logic               is_store,
    input  logic [31:0]        base_addr,
    input  logic [31:0]        stride,
    input  logic [31:0]        vl,
    input  logic [31:0]        vstart,
    input  logic [2:0]         vsew,
    input  logic               vm,
    input  logic [VLEN-1:0]    masks,
    input  logic [VLEN-1:0]    store_data,
    input  logic [VLEN-1:0]    old_vd,
    vector_lsu_if.master       mem,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [VLEN-1:0]    load_result
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ELEM, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;

    logic              is_store_r;
    logic [31:0]       base_r;
    logic [31:0]       stride_r;
    logic [31:0]       vl_r;
    logic [2:0]        vsew_r;
    logic              vm_r;
    logic [VLEN-1:0]   masks_r;
    logic [VLEN-1:0]   store_data_r;
    logic [31:0]       idx;
    logic              err_r;

    // log2(SEW): 3, 4 or 5 for the legal encodings
    logic [2:0]        sew_log2;
    logic [31:0]       max_el;
    logic              illegal;
    logic [31:0]       ea;
    logic              active;
    logic              misaligned;
    logic              last;
    logic [31:0]       bit_off;
    logic [31:0]       lane_mask;
    logic [31:0]       st_elem;
    logic [31:0]       rd_elem;
    logic [VLEN-1:0]   lane_vmask;
    logic              mem_go;

    assign sew_log2   = {1'b0, vsew_r[1:0]} + 3'd3;
    assign max_el     = 32'(VLEN) >> sew_log2;
    assign illegal    = (vsew_r > 3'd2) || (vl_r > max_el);
    assign ea         = base_r + idx * stride_r;
    assign active     = vm_r || (|(masks_r & (VLEN'(1) << idx)));
    assign misaligned = ((vsew_r[1:0] == 2'd1) && ea[0]) ||
                        ((vsew_r[1:0] == 2'd2) && (ea[1:0] != 2'b00));
    assign last       = (idx + 32'd1 == vl_r);
    assign bit_off    = idx << sew_log2;
    assign lane_mask  = (vsew_r[1:0] == 2'd0) ? 32'h0000_00ff :
                        (vsew_r[1:0] == 2'd1) ? 32'h0000_ffff : 32'hffff_ffff;
    assign st_elem    = 32'(store_data_r >> bit_off);
    assign rd_elem    = 32'(mem.mem_rdata >> {ea[1:0], 3'b000}) & lane_mask;
    assign lane_vmask = VLEN'(lane_mask) << bit_off;
    // a request is only raised for an active, aligned element
    assign mem_go     = (state == S_ELEM) && active && !misaligned;

    // state register
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CHECK;
            S_CHECK: begin
                if (illegal || idx >= vl_r) state_nxt = S_DONE;
                else                        state_nxt = S_ELEM;
            end
            S_ELEM: begin
                if (!active)                 state_nxt = last ? S_DONE : S_ELEM;
                else if (misaligned)         state_nxt = S_DONE;
                else if (mem.mem_ack && last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs: memory port is zero whenever no request is in flight
    always_comb begin
        mem.mem_req   = mem_go;
        mem.mem_we    = mem_go && is_store_r;
        mem.mem_addr  = 32'h0;
        mem.mem_wdata = 32'h0;
        mem.mem_be    = 4'h0;
        if (mem_go) begin
            mem.mem_addr = {ea[31:2], 2'b00};
            case (vsew_r[1:0])
                2'd0: begin
                    mem.mem_wdata = {4{st_elem[7:0]}};
                    mem.mem_be    = 4'b0001 << ea[1:0];
                end
                2'd1: begin
                    mem.mem_wdata = {2{st_elem[15:0]}};
                    mem.mem_be    = 4'b0011 << ea[1:0];
                end
                default: begin
                    mem.mem_wdata = st_elem;
                    mem.mem_be    = 4'b1111;
                end
            endcase
        end
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
        error = (state == S_DONE) && err_r;
    end

    // request latch, element index, error flag and result assembly
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            is_store_r   <= 1'b0;
            base_r       <= 32'h0;
            stride_r     <= 32'h0;
            vl_r         <= 32'h0;
            vsew_r       <= 3'h0;
            vm_r         <= 1'b0;
            masks_r      <= '0;
            store_data_r <= '0;
            idx          <= 32'h0;
            err_r        <= 1'b0;
            load_result  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    is_store_r   <= is_store;
                    base_r       <= base_addr;
                    stride_r     <= stride;
                    vl_r         <= vl;
                    vsew_r       <= vsew;
                    vm_r         <= vm;
                    masks_r      <= masks;
                    store_data_r <= store_data;
                    idx          <= vstart;
                    err_r        <= 1'b0;
                    load_result  <= old_vd;
                end
                S_CHECK: if (illegal) err_r <= 1'b1;
                S_ELEM: begin
                    if (!active) begin
                        idx <= idx + 32'd1;
                    end else if (misaligned) begin
                        err_r <= 1'b1;
                    end else if (mem.mem_ack) begin
                        if (!is_store_r)
                            load_result <= (load_result & ~lane_vmask) |
                                           (VLEN'(rd_elem) << bit_off);
                        idx <= idx + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lsu.sv
// tb/tb_vector_lsu.sv - scoreboard testbench for vector_lsu
module tb_vector_lsu;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit           err;
        logic [127:0] lr;
    } res_t;

    logic          SYS_clk = 1'b0;
    logic          SYS_reset = 1'b1;
    logic          start = 1'b0;
    logic          is_store = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [31:0]   stride = '0;
    logic [31:0]   vl = '0;
    logic [31:0]   vstart = '0;
    logic [2:0]    vsew = '0;
    logic          vm = 1'b1;
    logic [127:0]  masks = '0;
    logic [127:0]  store_data = '0;
    logic [127:0]  old_vd = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic [127:0]  load_result;

    vector_lsu_if bus ();

    vector_lsu #(.VLEN(128)) dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset   (SYS_reset),
        .start       (start),
        .is_store    (is_store),
        .base_addr   (base_addr),
        .stride      (stride),
        .vl          (vl),
        .vstart      (vstart),
        .vsew        (vsew),
        .vm          (vm),
        .masks       (masks),
        .store_data  (store_data),
        .old_vd      (old_vd),
        .mem         (bus.master),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .load_result (load_result)
    );

    always #5 SYS_clk = ~SYS_clk;

    int   n_checks = 0;
    int   n_errors = 0;
    txn_t exp_q[$];
    res_t res_q[$];
    int   ack_cnt = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    bit   mem_ready = 1'b0;
    logic [7:0] mem [0:4095];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory model: byte array, ack after ack_delay wait cycles
    assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
    assign bus.mem_rdata = {mem[{bus.mem_addr[11:2], 2'd3}], mem[{bus.mem_addr[11:2], 2'd2}],
                            mem[{bus.mem_addr[11:2], 2'd1}], mem[{bus.mem_addr[11:2], 2'd0}]};

    always @(posedge SYS_clk) begin
        if (SYS_reset && !mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h5a;
            mem_ready <= 1'b1;
        end else if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            for (int j = 0; j < 4; j++)
                if (bus.mem_be[j]) mem[{bus.mem_addr[11:2], 2'(j)}] <= bus.mem_wdata[j*8 +: 8];
        end
        if (SYS_reset) wait_cnt <= 0;
        else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // request monitor: hold stability while waiting, scoreboard compare on ack
    bit           held = 1'b0;
    logic [68:0]  hold_v;
    always @(negedge SYS_clk) begin
        if (SYS_reset) begin
            held = 1'b0;
        end else if (bus.mem_req) begin
            if (held)
                check("req_hold", {bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata}, hold_v);
            if (bus.mem_ack) begin
                txn_t t;
                held = 1'b0;
                ack_cnt++;
                check("txn_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    check("txn_addr", bus.mem_addr, t.addr);
                    check("txn_we", bus.mem_we, t.we);
                    check("txn_be", bus.mem_be, t.be);
                    if (t.we) check("txn_wdata", bus.mem_wdata, t.wdata);
                end
            end else begin
                held = 1'b1;
                hold_v = {bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata};
            end
        end else begin
            if (held) check("req_dropped", bus.mem_req, 1);
            held = 1'b0;
        end
    end

    // reference model: walks elements, queues expected transactions, returns expected result
    task automatic predict(input bit st, input logic [31:0] base, input logic [31:0] strd,
                           input logic [31:0] n, input logic [31:0] vst, input logic [2:0] sew,
                           input bit m, input logic [127:0] msk, input logic [127:0] sd,
                           input logic [127:0] ov, output bit perr, output logic [127:0] plr,
                           output int ntx);
        int nb;
        logic [31:0] ea;
        txn_t t;
        perr = 1'b0;
        plr = ov;
        ntx = 0;
        if (sew > 3'd2) begin perr = 1'b1; return; end
        nb = 1 << sew;
        if (n > 32'(16 / nb)) begin perr = 1'b1; return; end
        for (int i = int'(vst); i < int'(n); i++) begin
            if (!m && !msk[i]) continue;
            ea = base + 32'(i) * strd;
            if ((ea % 32'(nb)) != 0) begin perr = 1'b1; break; end
            t.addr = {ea[31:2], 2'b00};
            t.we = st;
            t.be = 4'(((1 << nb) - 1) << ea[1:0]);
            t.wdata = '0;
            for (int j = 0; j < 4; j++)
                t.wdata[j*8 +: 8] = sd[(i*nb + (j % nb))*8 +: 8];
            if (!st)
                for (int b = 0; b < nb; b++) plr[(i*nb + b)*8 +: 8] = mem[ea[11:0] + 12'(b)];
            exp_q.push_back(t);
            ntx++;
        end
    endtask

    task automatic run_op(input string name, input bit st, input logic [31:0] base,
                          input logic [31:0] strd, input logic [31:0] n, input logic [31:0] vst,
                          input logic [2:0] sew, input bit m, input logic [127:0] msk,
                          input logic [127:0] sd, input logic [127:0] ov, input int exp_lat,
                          output int acks);
        bit perr;
        logic [127:0] plr;
        int ntx;
        int a0;
        int cyc;
        bit busy_bad;
        res_t r;
        predict(st, base, strd, n, vst, sew, m, msk, sd, ov, perr, plr, ntx);
        res_q.push_back('{perr, plr});
        @(negedge SYS_clk);
        is_store = st; base_addr = base; stride = strd; vl = n; vstart = vst;
        vsew = sew; vm = m; masks = msk; store_data = sd; old_vd = ov;
        start = 1'b1;
        a0 = ack_cnt;
        @(negedge SYS_clk);
        start = 1'b0;
        cyc = 1;
        busy_bad = 1'b0;
        while (!done && cyc < 400) begin
            if (!busy) busy_bad = 1'b1;
            @(negedge SYS_clk);
            cyc++;
        end
        check({name, "_done"}, done, 1);
        check({name, "_busy"}, busy_bad, 0);
        if (exp_lat >= 0) check({name, "_latency"}, cyc, exp_lat);
        r = res_q.pop_front();
        check({name, "_error"}, error, r.err);
        check({name, "_result"}, load_result, r.lr);
        acks = ack_cnt - a0;
        check({name, "_acks"}, acks, ntx);
        check({name, "_txn_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge SYS_clk);
        check({name, "_pulse_end"}, {done, busy, error}, 3'b000);
    endtask

    initial begin
        int acks;
        int k;
        logic [127:0] sd;
        logic [127:0] ov;
        logic [2:0] rs;
        logic [31:0] rn;
        logic [31:0] rv;

        repeat (3) @(negedge SYS_clk);
        check("rst_outputs", {busy, done, error, bus.mem_req, bus.mem_we, bus.mem_be}, '0);
        check("rst_result", load_result, '0);
        #2 SYS_reset = 1'b0;

        // unit-stride SEW32 load, zero-wait
        ov = {4{32'hdead_beef}};
        run_op("t1", 1'b0, 32'h100, 32'd4, 32'd4, 32'd0, 3'd2, 1'b1, '0, '0, ov, 6, acks);
        check("t1_word0", load_result[31:0], 32'h5958_5b5a);

        // masked strided SEW8 store
        sd = {$urandom, $urandom, $urandom, $urandom};
        run_op("t2", 1'b1, 32'h200, 32'd3, 32'd4, 32'd0, 3'd0, 1'b0, 128'b0101, sd, ov, 6, acks);
        check("t2_acks", acks, 2);
        check("t2_mem206", mem[12'h206], sd[23:16]);
        check("t2_mem200", mem[12'h200], sd[7:0]);
        check("t2_mem203", mem[12'h203], 8'h03 ^ 8'h5a);

        // SEW16 load with delayed ack
        ack_delay = 3;
        run_op("t3", 1'b0, 32'h300, 32'd2, 32'd2, 32'd0, 3'd1, 1'b1, '0, '0, ov, -1, acks);
        check("t3_acks", acks, 2);
        ack_delay = 0;

        // illegal and boundary cases
        run_op("t4a", 1'b0, 32'h100, 32'd4, 32'd2, 32'd0, 3'd3, 1'b1, '0, '0, ov, 2, acks);
        run_op("t4b", 1'b0, 32'h100, 32'd4, 32'd5, 32'd0, 3'd2, 1'b1, '0, '0, ov, 2, acks);
        run_op("t4c", 1'b0, 32'h100, 32'd4, 32'd3, 32'd3, 3'd2, 1'b1, '0, '0, ov, 2, acks);
        check("t4c_result", load_result, ov);

        // misalignment
        run_op("t5a", 1'b0, 32'h102, 32'd4, 32'd4, 32'd0, 3'd2, 1'b1, '0, '0, ov, 3, acks);
        run_op("t5b", 1'b0, 32'h100, 32'd6, 32'd4, 32'd0, 3'd2, 1'b1, '0, '0, ov, 4, acks);
        check("t5b_acks", acks, 1);

        // reset during a pending request
        ack_delay = 1000;
        @(negedge SYS_clk);
        is_store = 1'b0; base_addr = 32'h100; stride = 32'd4; vl = 32'd4; vstart = 32'd0;
        vsew = 3'd2; vm = 1'b1; old_vd = {32{4'ha}}; start = 1'b1;
        @(negedge SYS_clk);
        start = 1'b0;
        k = 0;
        while (!bus.mem_req && k < 10) begin @(negedge SYS_clk); k++; end
        check("t6_req_pending", bus.mem_req, 1);
        @(negedge SYS_clk);
        #2 SYS_reset = 1'b1;
        #1;
        check("t6_rst_outputs", {bus.mem_req, busy, done, error}, 4'b0000);
        check("t6_rst_result", load_result, '0);
        @(negedge SYS_clk);
        #2 SYS_reset = 1'b0;
        ack_delay = 0;
        run_op("t6_after", 1'b0, 32'h100, 32'd4, 32'd4, 32'd0, 3'd2, 1'b1, '0, '0, ov, 6, acks);

        // randomised legal operations
        for (int it = 0; it < 4; it++) begin
            rs = 3'($urandom_range(0, 2));
            rn = 32'($urandom_range(1, 16 >> rs));
            rv = 32'($urandom_range(0, int'(rn) - 1));
            ack_delay = $urandom_range(0, 2);
            sd = {$urandom, $urandom, $urandom, $urandom};
            ov = {$urandom, $urandom, $urandom, $urandom};
            run_op("rnd", 1'($urandom_range(0, 1)), 32'h800 + 32'($urandom_range(0, 15)) * 4,
                   32'((1 << rs) * $urandom_range(1, 3)), rn, rv, rs, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom, $urandom, $urandom}, sd, ov, -1, acks);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
